md_sequencer: RTL

Controller for the multi-cycle multiply/divide resource beside the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and holds the HI/LO result for a fixed latency before committing it. It also exports the busy/start/countdown status that decode uses to stall HI/LO users. An interrupt flush cancels any in-flight operation without disturbing architectural HI/LO.

---
 rtl/md_sequencer_pkg.sv | 22 ++
 rtl/md_sequencer_if.sv | 27 ++
 rtl/md_sequencer_arith.sv | 66 ++++++
 rtl/md_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies and FSM state constants.
package md_sequencer_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   localparam int MD_MUL_LAT_DEF = 5;
   localparam int MD_DIV_LAT_DEF = 10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_sequencer_if.sv
// Bundle between the EX/decode side and the multiply/divide sequencer.
interface md_sequencer_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        flush;
   logic        d_uses_md;
   logic        start;
   logic        busy;
   logic [4:0]  busy_cnt;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   // Pipeline side: issues ops, observes status and HI/LO
   modport master (
      output op_valid, op, opa, opb, flush, d_uses_md,
      input  start, busy, busy_cnt, stall, hi, lo
   );

   // Sequencer side
   modport slave (
      input  op_valid, op, opa, opb, flush, d_uses_md,
      output start, busy, busy_cnt, stall, hi, lo
   );
endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational multiply/divide datapath. Result packs {hi, lo}:
// products as {upper, lower}, divides as {remainder, quotient}.
module md_arith
   import md_sequencer_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        b_zero;
   logic [31:0] div_u;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [31:0] quo_u;
   logic [31:0] rem_u;

   assign prod_s = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
   assign prod_u = {32'd0, opa} * {32'd0, opb};

   // Divisor forced to 1 on zero so the dividers never see a zero operand;
   // the commit is suppressed through div_by_zero anyway.
   assign b_zero = (opb == 32'd0);
   assign div_u  = b_zero ? 32'd1 : opb;
   assign quo_u  = opa / div_u;
   assign rem_u  = opa % div_u;

   // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign abs_a = opa[31] ? (32'd0 - opa) : opa;
   assign abs_b = b_zero ? 32'd1 : (opb[31] ? (32'd0 - opb) : opb);
   assign q_mag = abs_a / abs_b;
   assign r_mag = abs_a % abs_b;
   assign quo_s = (opa[31] ^ opb[31]) ? (32'd0 - q_mag) : q_mag;
   assign rem_s = opa[31] ? (32'd0 - r_mag) : r_mag;

   // Select the result for the requested op
   always_comb begin
      result      = 64'd0;
      div_by_zero = 1'b0;
      case (op)
         MD_MULT:  result = prod_s;
         MD_MULTU: result = prod_u;
         MD_DIV: begin
            result      = {rem_s, quo_s};
            div_by_zero = b_zero;
         end
         MD_DIVU: begin
            result      = {rem_u, quo_u};
            div_by_zero = b_zero;
         end
         default: begin
            result      = 64'd0;
            div_by_zero = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: accepts arithmetic and MTHI/MTLO ops, holds
// arithmetic results for a fixed latency, then commits them to HI/LO.
// Flush cancels an in-flight op without touching HI/LO.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int MUL_LAT = MD_MUL_LAT_DEF,
   parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
   input logic          clk,
   input logic          reset,
   md_sequencer_if.slave bus
);

   localparam logic [4:0] MUL_CNT = 5'(MUL_LAT);
   localparam logic [4:0] DIV_CNT = 5'(DIV_LAT);

   md_state_e   state;
   logic        busy;
   logic [4:0]  busy_cnt;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        pend_dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   logic        accept;
   logic        start;
   logic        is_mul;
   logic [63:0] result;
   logic        div_by_zero;

   md_arith u_arith (
      .op          (bus.op),
      .opa         (bus.opa),
      .opb         (bus.opb),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   assign accept = bus.op_valid & ~busy & ~bus.flush & (bus.op <= MD_MTLO);
   assign start  = accept & (bus.op <= MD_DIVU);
   assign is_mul = (bus.op == MD_MULT) || (bus.op == MD_MULTU);

   assign bus.start    = start;
   assign bus.stall    = bus.d_uses_md & (start | busy);
   assign bus.busy     = busy;
   assign bus.busy_cnt = busy_cnt;
   assign bus.hi       = hi;
   assign bus.lo       = lo;

   // FSM, latency counter, pending result and architectural HI/LO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= MD_IDLE;
         busy     <= 1'b0;
         busy_cnt <= 5'd0;
         pend_hi  <= 32'd0;
         pend_lo  <= 32'd0;
         pend_dbz <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
      end else if (bus.flush) begin
         state    <= MD_IDLE;
         busy     <= 1'b0;
         busy_cnt <= 5'd0;
         pend_hi  <= 32'd0;
         pend_lo  <= 32'd0;
         pend_dbz <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  pend_hi  <= result[63:32];
                  pend_lo  <= result[31:0];
                  pend_dbz <= div_by_zero;
                  busy_cnt <= is_mul ? MUL_CNT : DIV_CNT;
                  busy     <= 1'b1;
                  state    <= MD_RUN;
               end else if (accept && (bus.op == MD_MTHI)) begin
                  hi <= bus.opa;
               end else if (accept && (bus.op == MD_MTLO)) begin
                  lo <= bus.opa;
               end
            end
            MD_RUN: begin
               if (busy_cnt == 5'd1) begin
                  if (!pend_dbz) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  busy_cnt <= 5'd0;
                  busy     <= 1'b0;
                  state    <= MD_IDLE;
               end else begin
                  busy_cnt <= busy_cnt - 5'd1;
               end
            end
            default: begin
               state    <= MD_IDLE;
               busy     <= 1'b0;
               busy_cnt <= 5'd0;
            end
         endcase
      end
   end

endmodule
